// File: rtl/std_op_driver.sv
// Initiator side of the std valid/ready + read_in/read_out operator handshake.
// Latches one operand pair per go, drives the operator, and captures the result or times out.
module std_op_driver #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left_in,
   input  logic [WIDTH-1:0] right_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_read_out,
   output logic             err,
   output logic [WIDTH-1:0] op_left,
   output logic             op_left_read_in,
   output logic [WIDTH-1:0] op_right,
   output logic             op_right_read_in,
   output logic             op_valid,
   input  logic             op_ready,
   input  logic [WIDTH-1:0] op_out,
   input  logic             op_out_read_out
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2,
      ERR  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] left_q, left_d;
   logic [WIDTH-1:0] right_q, right_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             err_q, err_d;

   logic             response;
   logic             last_cycle;

   assign response   = op_ready && op_out_read_out;
   assign last_cycle = (cnt_q == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         left_q         <= '0;
         right_q        <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         left_q         <= left_d;
         right_q        <= right_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_q          <= err_d;
      end
   end

   // A response in the last allowed BUSY cycle still wins over the timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (go) state_d = BUSY;
         BUSY: begin
            if (response)        state_d = DONE;
            else if (last_cycle) state_d = ERR;
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status flags are set on entry to DONE/ERR so they are visible alongside the done pulse.
   always_comb begin
      cnt_d          = cnt_q;
      left_d         = left_q;
      right_d        = right_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      err_d          = err_q;
      case (state_q)
         IDLE: begin
            if (go) begin
               left_d         = left_in;
               right_d        = right_in;
               cnt_d          = '0;
               result_valid_d = 1'b0;
               err_d          = 1'b0;
            end
         end
         BUSY: begin
            if (response) begin
               result_d       = op_out;
               result_valid_d = 1'b1;
            end else if (last_cycle) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy             = (state_q != IDLE);
      done             = (state_q == DONE) || (state_q == ERR);
      op_valid         = (state_q == BUSY);
      op_left_read_in  = (state_q == BUSY);
      op_right_read_in = (state_q == BUSY);
   end

   assign op_left         = left_q;
   assign op_right        = right_q;
   assign result          = result_q;
   assign result_read_out = result_valid_q;
   assign err             = err_q;

endmodule

// File: tb/tb_std_op_driver.sv
// Bench for std_op_driver: a stub adder operator with programmable response cycle,
// directed vector table, reset corner sequences and randomized transactions.
module tb_std_op_driver;

   localparam int W  = 32;
   localparam int TO = 4;

   logic          clk;
   logic          reset;
   logic          go;
   logic [W-1:0]  left_in;
   logic [W-1:0]  right_in;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          result_read_out;
   logic          err;
   logic [W-1:0]  op_left;
   logic          op_left_read_in;
   logic [W-1:0]  op_right;
   logic          op_right_read_in;
   logic          op_valid;
   logic          op_ready;
   logic [W-1:0]  op_out;
   logic          op_out_read_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] m_result;
   logic         m_valid;
   logic         m_err;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           k;
      bit           hold_go;
      logic [W-1:0] exp_result;
      logic         exp_err;
   } vec_t;

   vec_t vecs[7];

   std_op_driver #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk              (clk),
      .reset            (reset),
      .go               (go),
      .left_in          (left_in),
      .right_in         (right_in),
      .busy             (busy),
      .done             (done),
      .result           (result),
      .result_read_out  (result_read_out),
      .err              (err),
      .op_left          (op_left),
      .op_left_read_in  (op_left_read_in),
      .op_right         (op_right),
      .op_right_read_in (op_right_read_in),
      .op_valid         (op_valid),
      .op_ready         (op_ready),
      .op_out           (op_out),
      .op_out_read_out  (op_out_read_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic driveJunk();
      op_ready        = 1'($urandom_range(0, 1));
      op_out_read_out = 1'($urandom_range(0, 1));
      op_out          = $urandom;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_busy"}, W'(busy), '0);
      checkOutput({tag, "_done"}, W'(done), '0);
      checkOutput({tag, "_op_valid"}, W'(op_valid), '0);
      checkOutput({tag, "_result"}, result, m_result);
      checkOutput({tag, "_rro"}, W'(result_read_out), W'(m_valid));
      checkOutput({tag, "_err"}, W'(err), W'(m_err));
   endtask

   // One request: accept in IDLE, k-th BUSY cycle responds (out of range means never), then the done cycle.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int k, input bit hold_go);
      bit timed_out;
      int n;
      int sel;
      timed_out = !(k >= 1 && k <= TO);
      n = timed_out ? TO : k;
      checkIdle("idle");
      go       = 1'b1;
      left_in  = a;
      right_in = b;
      driveJunk();
      step();
      for (int i = 1; i <= n; i++) begin
         checkOutput("busy_busy", W'(busy), W'(1));
         checkOutput("busy_done", W'(done), '0);
         checkOutput("busy_op_valid", W'(op_valid), W'(1));
         checkOutput("busy_left_ri", W'(op_left_read_in), W'(1));
         checkOutput("busy_right_ri", W'(op_right_read_in), W'(1));
         checkOutput("busy_op_left", op_left, a);
         checkOutput("busy_op_right", op_right, b);
         checkOutput("busy_rro", W'(result_read_out), '0);
         checkOutput("busy_err", W'(err), '0);
         checkOutput("busy_result", result, m_result);
         go       = hold_go ? 1'b1 : 1'($urandom_range(0, 1));
         left_in  = $urandom;
         right_in = $urandom;
         if (i == k) begin
            op_ready        = 1'b1;
            op_out_read_out = 1'b1;
            op_out          = a + b;
         end else begin
            sel             = $urandom_range(0, 2);
            op_ready        = (sel == 1);
            op_out_read_out = (sel == 2);
            op_out          = $urandom;
         end
         step();
      end
      if (timed_out) begin
         m_err   = 1'b1;
         m_valid = 1'b0;
      end else begin
         m_err    = 1'b0;
         m_valid  = 1'b1;
         m_result = a + b;
      end
      checkOutput("fin_done", W'(done), W'(1));
      checkOutput("fin_busy", W'(busy), W'(1));
      checkOutput("fin_op_valid", W'(op_valid), '0);
      checkOutput("fin_left_ri", W'(op_left_read_in), '0);
      checkOutput("fin_err", W'(err), W'(m_err));
      checkOutput("fin_rro", W'(result_read_out), W'(m_valid));
      checkOutput("fin_result", result, m_result);
      go = hold_go ? 1'b1 : 1'($urandom_range(0, 1));
      driveJunk();
      step();
   endtask

   initial begin
      vecs[0] = '{a: 32'd7,          b: 32'd5,   k: 1,      hold_go: 1'b0, exp_result: 32'd12,  exp_err: 1'b0};
      vecs[1] = '{a: 32'd9,          b: 32'd9,   k: 0,      hold_go: 1'b0, exp_result: 32'd12,  exp_err: 1'b1};
      vecs[2] = '{a: 32'hFFFFFFFF,   b: 32'd1,   k: 3,      hold_go: 1'b0, exp_result: 32'd0,   exp_err: 1'b0};
      vecs[3] = '{a: 32'd1,          b: 32'd1,   k: 1,      hold_go: 1'b1, exp_result: 32'd2,   exp_err: 1'b0};
      vecs[4] = '{a: 32'd2,          b: 32'd2,   k: 1,      hold_go: 1'b1, exp_result: 32'd4,   exp_err: 1'b0};
      vecs[5] = '{a: 32'd100,        b: 32'd23,  k: TO,     hold_go: 1'b0, exp_result: 32'd123, exp_err: 1'b0};
      vecs[6] = '{a: 32'd5,          b: 32'd6,   k: TO + 1, hold_go: 1'b0, exp_result: 32'd123, exp_err: 1'b1};

      reset    = 1'b1;
      go       = 1'b1;
      left_in  = 32'd3;
      right_in = 32'd4;
      op_ready = 1'b1;
      op_out_read_out = 1'b1;
      op_out   = 32'hDEAD;
      m_result = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;

      step();
      checkIdle("rst1");
      step();
      checkIdle("rst2");
      checkOutput("rst2_left_ri", W'(op_left_read_in), '0);
      checkOutput("rst2_right_ri", W'(op_right_read_in), '0);
      reset = 1'b0;
      go    = 1'b0;
      step();
      checkIdle("post_rst");

      for (int v = 0; v < 7; v++) begin
         applyStimulus(vecs[v].a, vecs[v].b, vecs[v].k, vecs[v].hold_go);
         checkOutput("tbl_result", result, vecs[v].exp_result);
         checkOutput("tbl_err", W'(err), W'(vecs[v].exp_err));
      end

      for (int r = 0; r < 40; r++) begin
         applyStimulus($urandom, $urandom, $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
      end

      $display("[TB] reset during BUSY");
      checkIdle("mid_idle");
      go       = 1'b1;
      left_in  = 32'd11;
      right_in = 32'd22;
      step();
      go = 1'b0;
      op_ready = 1'b0;
      op_out_read_out = 1'b0;
      checkOutput("mid_b1_op_valid", W'(op_valid), W'(1));
      step();
      checkOutput("mid_b2_op_valid", W'(op_valid), W'(1));
      reset = 1'b1;
      step();
      m_result = '0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      checkIdle("mid_rst");
      checkOutput("mid_rst_op_left", op_left, '0);
      reset = 1'b0;
      step();
      checkOutput("mid_after_done", W'(done), '0);
      checkOutput("mid_after_busy", W'(busy), '0);
      applyStimulus(32'd11, 32'd22, 2, 1'b0);
      checkOutput("mid_clean_result", result, 32'd33);
      go = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
